// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
//   8N1 UART receiver feeding a small first-word-fall-through receive FIFO.
//   The rxd pin is synchronised, framed by a bit-timed state machine
//   (start / 8 data bits LSB first / stop), and completed bytes are pushed
//   into a circular buffer that the CPU drains with rd_en.
//
// Ports
//   clk          system clock
//   resetn       synchronous, active-low reset
//   rxd          asynchronous serial input, idle high
//   rd_en        pop the head byte (ignored when empty)
//   clr_err      one-cycle pulse clearing frame_error and overrun
//   rd_data      byte at the FIFO head, 0 when empty
//   rx_valid     FIFO not empty
//   count        number of bytes held
//   frame_error  sticky: a stop bit was sampled low
//   overrun      sticky: a byte was dropped because the FIFO was full
module uart_rx_fifo #(
  parameter int CLK_FREQ_HZ = 12000000,
  parameter int BAUD_RATE   = 9600,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          rxd,
  input  logic                          rd_en,
  input  logic                          clr_err,
  output logic [7:0]                    rd_data,
  output logic                          rx_valid,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          frame_error,
  output logic                          overrun
);

  localparam int N  = CLK_FREQ_HZ / BAUD_RATE;
  localparam int H  = N / 2;
  localparam int TW = $clog2(N);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  // The timer restarts at 0 on every state entry, so an interval of P
  // cycles ends when it reads P-1.
  localparam logic [TW-1:0] HALF_LAST = TW'(H - 1);
  localparam logic [TW-1:0] BIT_LAST  = TW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  logic          rxd_p0;
  logic          rxd_p1;
  logic          rxd_s;
  logic          rxd_prev;

  state_t        state;
  logic [TW-1:0] timer;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;

  logic          half_done;
  logic          bit_done;
  logic          push_req;
  logic          ferr_set;
  logic          ovr_set;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          empty;
  logic          full;
  logic          do_push;
  logic          do_pop;

  // Stage p0/p1: two-flop synchroniser; rxd_prev holds the previous rxd_s
  // for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      rxd_p0   <= 1'b1;
      rxd_p1   <= 1'b1;
      rxd_prev <= 1'b1;
    end else begin
      rxd_p0   <= rxd;
      rxd_p1   <= rxd_p0;
      rxd_prev <= rxd_p1;
    end
  end

  assign rxd_s = rxd_p1;

  assign half_done = (timer == HALF_LAST);
  assign bit_done  = (timer == BIT_LAST);
  assign push_req  = (state == S_STOP) && bit_done && rxd_s;
  assign ferr_set  = (state == S_STOP) && bit_done && !rxd_s;

  // Framing state machine.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= S_IDLE;
      timer   <= '0;
      bit_idx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          timer <= '0;
          if (rxd_prev && !rxd_s) state <= S_START;
        end
        S_START: begin
          if (half_done) begin
            timer   <= '0;
            bit_idx <= '0;
            // A line that is high again at mid-start was a glitch.
            state   <= rxd_s ? S_IDLE : S_DATA;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_DATA: begin
          if (bit_done) begin
            timer          <= '0;
            shift[bit_idx] <= rxd_s;
            if (bit_idx == 3'd7) state <= S_STOP;
            else bit_idx <= bit_idx + 3'd1;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_STOP: begin
          if (bit_done) begin
            timer <= '0;
            state <= rxd_s ? S_IDLE : S_BREAK;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_BREAK: begin
          // Hold off until the line recovers so a long low is not re-read
          // as a stream of start bits.
          timer <= '0;
          if (rxd_s) state <= S_IDLE;
        end
        default: begin
          timer <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign empty   = (cnt == '0);
  assign full    = (cnt == CW'(FIFO_DEPTH));
  assign do_pop  = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign do_push = push_req && (!full || do_pop);
  assign ovr_set = push_req && full && !do_pop;

  // Receive buffer storage.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= shift;
  end

  // Buffer pointers, occupancy and sticky flags.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
      // Set takes priority over a coincident clear.
      frame_error <= ferr_set || (frame_error && !clr_err);
      overrun     <= ovr_set  || (overrun && !clr_err);
    end
  end

  assign rx_valid = !empty;
  assign count    = cnt;
  assign rd_data  = empty ? 8'h00 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
module tb_uart_rx_fifo;

  localparam int DEPTH = 4;
  localparam int NB    = 16;          // clock cycles per bit
  localparam int FRAME = 10 * NB;     // one 8N1 frame

  logic       clk;
  logic       resetn;
  logic       rxd;
  logic       rd_en;
  logic       clr_err;
  logic [7:0] rd_data;
  logic       rx_valid;
  logic [2:0] count;
  logic       frame_error;
  logic       overrun;

  uart_rx_fifo #(
    .CLK_FREQ_HZ(16),
    .BAUD_RATE  (1),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rxd        (rxd),
    .rd_en      (rd_en),
    .clr_err    (clr_err),
    .rd_data    (rd_data),
    .rx_valid   (rx_valid),
    .count      (count),
    .frame_error(frame_error),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the bytes the CPU should see, and the two sticky flags.
  logic [7:0] mq[$];
  bit         m_ferr;
  bit         m_ovr;

  int         vectors;
  int         miscompares;

  int          first_valid_k;
  logic [7:0]  pop_seen;
  logic [7:0]  exp_pop;
  logic [13:0] rst_snap;

  function automatic logic [13:0] model_vec();
    logic [7:0] head;
    head = (mq.size() > 0) ? mq[0] : 8'h00;
    return {mq.size() > 0, 3'(mq.size()), head, m_ferr, m_ovr};
  endfunction

  function automatic logic [13:0] dut_vec();
    return {rx_valid, count, rd_data, frame_error, overrun};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pop_byte();
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  task automatic clear_flags();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    m_ferr = 0;
    m_ovr  = 0;
  endtask

  // Drives one frame, one bit per NB cycles, starting at the current
  // negedge (call index k = 0). pop_k / clr_k / rst_k select a frame cycle
  // at which rd_en, clr_err or resetn (low) is driven for one cycle; -1
  // means none. The stop sample edge is k = 155, so index 154 makes a pop
  // or clear coincide with the push / flag set.
  task automatic send_frame(input logic [7:0] b, input bit stop_bit,
                            input int pop_k, input int clr_k, input int rst_k);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    first_valid_k = -1;
    exp_pop = (mq.size() > 0) ? mq[0] : 8'h00;
    for (int k = 0; k < FRAME; k++) begin
      if (first_valid_k < 0 && rx_valid) first_valid_k = k;
      if (k == pop_k) pop_seen = rd_data;
      if (rst_k >= 0 && k == rst_k + 1) rst_snap = dut_vec();
      rxd     = bits[k / NB];
      rd_en   = (k == pop_k);
      clr_err = (k == clr_k);
      resetn  = !(k == rst_k);
      @(negedge clk);
    end
    rd_en   = 1'b0;
    clr_err = 1'b0;
    resetn  = 1'b1;
    if (rst_k >= 0) begin
      mq.delete();
      m_ferr = 0;
      m_ovr  = 0;
    end else begin
      if (clr_k >= 0) begin
        m_ferr = 0;
        m_ovr  = 0;
      end
      if (pop_k >= 0 && mq.size() > 0) void'(mq.pop_front());
      if (stop_bit) begin
        if (mq.size() < DEPTH) mq.push_back(b);
        else m_ovr = 1;
      end else begin
        m_ferr = 1;
      end
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    rxd    = 1'b1;
    idle(3);
    vectors++;
    if (dut_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL reset_hold: got %h want %h", dut_vec(), model_vec());
    end
    resetn = 1'b1;
    idle(5);
    vectors++;
    if (dut_vec() !== 14'h0) begin
      miscompares++;
      $display("FAIL reset_release: got %h want %h", dut_vec(), 14'h0);
    end
  endtask

  task automatic test_single();
    send_frame(8'hA5, 1'b1, -1, -1, -1);
    // Line falls at k=0, first captured at k=1, T starts at k=2: T+8+144+1.
    vectors++;
    if (first_valid_k !== 155) begin
      miscompares++;
      $display("FAIL single_latency: got %0d want %0d", first_valid_k, 155);
    end
    vectors++;
    if (dut_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL single_rx: got %h want %h", dut_vec(), model_vec());
    end
    pop_byte();
    vectors++;
    if (dut_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL single_pop: got %h want %h", dut_vec(), model_vec());
    end
    pop_byte();
    vectors++;
    if (dut_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL pop_empty: got %h want %h", dut_vec(), model_vec());
    end
  endtask

  task automatic test_glitch();
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(40);
    vectors++;
    if (dut_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL glitch_quiet: got %h want %h", dut_vec(), model_vec());
    end
    send_frame(8'h5A, 1'b1, -1, -1, -1);
    vectors++;
    if (dut_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL glitch_next: got %h want %h", dut_vec(), model_vec());
    end
    pop_byte();
  endtask

  task automatic test_frame_error();
    send_frame(8'h3C, 1'b0, -1, -1, -1);
    idle(3 * NB);
    vectors++;
    if (dut_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL ferr_break: got %h want %h", dut_vec(), model_vec());
    end
    rxd = 1'b1;
    idle(20);
    send_frame(8'h55, 1'b1, -1, -1, -1);
    vectors++;
    if (dut_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL ferr_after: got %h want %h", dut_vec(), model_vec());
    end
    clear_flags();
    vectors++;
    if (dut_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL ferr_clear: got %h want %h", dut_vec(), model_vec());
    end
    pop_byte();
  endtask

  task automatic test_overrun_wrap();
    for (int i = 1; i <= 5; i++)
      // The dropping frame carries a coincident clear: overrun must win.
      send_frame(8'(i), 1'b1, -1, (i == 5) ? 154 : -1, -1);
    vectors++;
    if (dut_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL overrun_full: got %h want %h", dut_vec(), model_vec());
    end
    for (int i = 0; i < 4; i++) begin
      pop_byte();
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL overrun_drain%0d: got %h want %h", i, dut_vec(), model_vec());
      end
    end
    clear_flags();
    for (int i = 6; i <= 11; i++) begin
      send_frame(8'(i), 1'b1, -1, -1, -1);
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL wrap_%0d: got %h want %h", i, dut_vec(), model_vec());
      end
      pop_byte();
    end
  endtask

  task automatic test_full_push_pop();
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, -1, -1, -1);
    send_frame(8'h14, 1'b1, 154, -1, -1);
    vectors++;
    if (pop_seen !== exp_pop) begin
      miscompares++;
      $display("FAIL fullpp_head: got %h want %h", pop_seen, exp_pop);
    end
    vectors++;
    if (dut_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL fullpp_state: got %h want %h", dut_vec(), model_vec());
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL fullpp_order%0d: got %h want %h", i, dut_vec(), model_vec());
      end
      pop_byte();
    end
  endtask

  task automatic test_random();
    logic [7:0] b;
    bit         stp;
    int         clr_k;
    int         npop;
    for (int f = 0; f < 20; f++) begin
      b     = 8'($urandom);
      stp   = ($urandom_range(0, 4) != 0);
      clr_k = ($urandom_range(0, 3) == 0) ? 154 : -1;
      send_frame(b, stp, -1, clr_k, -1);
      if (!stp) begin
        idle($urandom_range(0, 40));
        rxd = 1'b1;
        idle(20);
      end
      vectors++;
      if (dut_vec() !== model_vec()) begin
        miscompares++;
        $display("FAIL random_rx%0d: got %h want %h", f, dut_vec(), model_vec());
      end
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        pop_byte();
        vectors++;
        if (dut_vec() !== model_vec()) begin
          miscompares++;
          $display("FAIL random_pop%0d_%0d: got %h want %h", f, p, dut_vec(), model_vec());
        end
      end
    end
    while (mq.size() > 0) pop_byte();
    clear_flags();
  endtask

  task automatic test_reset_mid();
    // Leave a byte and a frame error behind so the reset has something to clear.
    send_frame(8'h42, 1'b1, -1, -1, -1);
    send_frame(8'h00, 1'b0, -1, -1, -1);
    rxd = 1'b1;
    idle(20);
    // Reset lands in data bit 3 (frame bit 4 spans k = 64..79).
    send_frame(8'hFF, 1'b1, -1, -1, 70);
    vectors++;
    if (rst_snap !== 14'h0) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got %h want %h", rst_snap, 14'h0);
    end
    idle(20);
    vectors++;
    if (dut_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL reset_mid_nopush: got %h want %h", dut_vec(), model_vec());
    end
    send_frame(8'h81, 1'b1, -1, -1, -1);
    vectors++;
    if (dut_vec() !== model_vec()) begin
      miscompares++;
      $display("FAIL reset_mid_next: got %h want %h", dut_vec(), model_vec());
    end
    pop_byte();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    m_ferr      = 0;
    m_ovr       = 0;
    resetn      = 1'b0;
    rxd         = 1'b1;
    rd_en       = 1'b0;
    clr_err     = 1'b0;
    @(negedge clk);
    test_reset();
    test_single();
    test_glitch();
    test_frame_error();
    test_overrun_wrap();
    test_full_push_pop();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

UART receiver with a small receive FIFO, the receive-side counterpart of the SoC's UART transmitter. It samples the asynchronous RXD pin as 8N1 serial data, assembles bytes LSB first and buffers them for the CPU. The SoC exposes it in the IO page: a read of the data word pops one byte, and a read of the control word returns valid/error status.

## Interface
- CLK_FREQ_HZ, 12000000, system clock frequency.
- BAUD_RATE, 9600, serial bit rate. Bit period N = CLK_FREQ_HZ/BAUD_RATE, using integer division; N must be at least 8.
- FIFO_DEPTH, 4, number of receive buffer entries; must be a power of two, at least 2.
- clk  in  1  system clock.
- resetn  in  1  synchronous, active-low reset.
- rxd  in  1  asynchronous serial input; idle state is high.
- rd_en  in  1  pop request; ignored when FIFO is empty.
- clr_err  in  1  one-cycle pulse that clears the sticky error flags.
- rd_data  out  8  byte at the FIFO head (first-word fall-through); 0 when empty.
- rx_valid  out  1  FIFO not empty.
- count  out  $clog2(FIFO_DEPTH)+1  number of bytes held.
- frame_error  out  1  sticky; set when a stop bit is sampled low.
- overrun  out  1  sticky; set when a byte is dropped because the FIFO is full.

## Operation
- Synchronizer: rxd passes through 2 flip-flops to give rxd_s. All logic uses rxd_s only.
- Bit timer: a counter of width $clog2(N). It reloads on every state entry.
- State machine, with H = N/2 (integer division):
  - IDLE: on a falling edge of rxd_s (previous 1, current 0), go to START.
  - START: after H cycles, sample rxd_s. If it is 0, go to DATA with bit index 0. If it is 1, the start is false: go to IDLE, no flags change.
  - DATA: every N cycles, sample rxd_s into bit[index] (LSB first). After bit 7, go to STOP.
  - STOP: after N cycles, sample rxd_s.
    - If 1: push the byte, go to IDLE.
    - If 0: set frame_error, discard the byte, go to BREAK.
  - BREAK: wait until rxd_s = 1, then go to IDLE. This prevents a held-low line (break) from being taken as repeated start bits.
- FIFO: circular buffer with read and write pointers and an occupancy counter. Push, pop and wrap-around follow the usual rules.
  - Push while full: the byte is dropped, overrun is set, FIFO contents are unchanged.
  - Push and pop in the same cycle, including when full: both occur, count is unchanged, no overrun.
  - Pop when empty: no effect.
- Sticky flags: cleared by clr_err. If a set event and clr_err occur in the same cycle, the set wins.
- Reset:
  - Returns the FSM to IDLE and empties the FIFO.
  - Clears frame_error and overrun.
  - Synchronizer flip-flops reset to 1.
  - A frame in progress at reset is discarded.
  - All outputs are 0 after reset.

## Timing
- Let T be the cycle in which the IDLE falling edge is detected on rxd_s. T is 2 cycles after the physical rxd edge is first registered.
- Sampling points:
  - Start check: cycle T+H.
  - Data bit i (i = 0..7): cycle T+H+(i+1)·N.
  - Stop bit: cycle T+H+9·N.
- The pushed byte is visible one cycle after the stop sample: rx_valid, count and rd_data update in that cycle.
- frame_error and overrun assert one cycle after the causing sample.
- After a valid stop bit, the FSM is back in IDLE in the next cycle, so back-to-back frames with a single stop bit are received.
- Pop: with rd_en high in cycle C, the next entry (or 0, with rx_valid low) is presented in cycle C+1.
- Reset is sampled on the clock edge; outputs are 0 in the cycle after resetn is sampled low.

## Test plan
Benches use CLK_FREQ_HZ=16, BAUD_RATE=1 (so N=16, H=8) and FIFO_DEPTH=4.
- Single byte: send 0xA5 (8N1). Required response: rx_valid rises exactly at T+8+144+1; rd_data=0xA5; count=1. One rd_en pulse then gives rx_valid=0, count=0, rd_data=0.
- Glitch: pulse rxd low for 4 cycles, then hold high. Required response: no push, no flags, FSM returns to IDLE. A following 0x5A is received correctly.
- Frame error and break:
  - Send 0x3C with its stop bit 0, then hold rxd low for 3 bit times, then high. Required response: frame_error=1, count=0.
  - Then send 0x55. Required response: count=1, rd_data=0x55.
  - Pulse clr_err. Required response: frame_error=0.
- Overrun and wrap: send 0x01..0x05 back-to-back without popping.
  - Required response: count=4, overrun=1.
  - Pops return 0x01, 0x02, 0x03, 0x04 in order, then the FIFO is empty.
  - Repeat with 0x06..0x0B, popping one byte per frame, so the pointers wrap several times. Required response: data stays in order, no overrun.
- Simultaneous full push and pop: with the FIFO full of 0x10..0x13, assert rd_en in the cycle 0x14 is pushed. Required response: count stays 4, overrun=0, pop order is 0x11, 0x12, 0x13, 0x14.
- Reset mid-frame: assert resetn=0 for 1 cycle during data bit 3 of 0xFF. Required response: all outputs 0; no byte is pushed from the rest of the frame; the next clean frame 0x81 is received correctly.
